// File: rtl/cell_sequencer.sv
// Cell sequencer: gathers 3x3 pixel pairs into packed cell vectors, issues them
// to the cell processor, captures the processed pixel and hands it downstream.
module cell_sequencer #(
  parameter int PIXEL_W      = 24,
  parameter int CELL_PIXELS  = 9,
  parameter int PROC_LATENCY = 4,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_cells,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [31:0]                    pix_a,
  input  logic [31:0]                    pix_b,
  output logic [PIXEL_W*CELL_PIXELS-1:0] cell_a,
  output logic [PIXEL_W*CELL_PIXELS-1:0] cell_b,
  output logic                           cell_issue,
  input  logic [PIXEL_W-1:0]             result_pixel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PIXEL_W-1:0]             out_pixel,
  output logic                           busy,
  output logic                           done
);

  localparam int CELL_W = PIXEL_W * CELL_PIXELS;
  localparam int K_W    = (CELL_PIXELS > 1) ? $clog2(CELL_PIXELS) : 1;
  localparam int WAIT_W = $clog2(PROC_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CELL_W-1:0]   cell_a_q, cell_a_d;
  logic [CELL_W-1:0]   cell_b_q, cell_b_d;
  logic [PIXEL_W-1:0]  out_pixel_q, out_pixel_d;
  logic [CNT_W-1:0]    cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      wait_q      <= '0;
      cell_a_q    <= '0;
      cell_b_q    <= '0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      wait_q      <= wait_d;
      cell_a_q    <= cell_a_d;
      cell_b_q    <= cell_b_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    wait_d      = wait_q;
    cell_a_d    = cell_a_q;
    cell_b_d    = cell_b_q;
    out_pixel_d = out_pixel_q;
    pix_ready   = 1'b0;
    cell_issue  = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_cells != '0) begin
            num_d    = num_cells;
            cnt_d    = '0;
            k_d      = '0;
            cell_a_d = '0;
            cell_b_d = '0;
            state_d  = S_GATHER;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GATHER: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          cell_a_d[k_q*PIXEL_W +: PIXEL_W] = pix_a[PIXEL_W-1:0];
          cell_b_d[k_q*PIXEL_W +: PIXEL_W] = pix_b[PIXEL_W-1:0];
          if (k_q == K_W'(CELL_PIXELS - 1)) begin
            state_d = S_ISSUE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      S_ISSUE: begin
        cell_issue = 1'b1;
        wait_d     = WAIT_W'(PROC_LATENCY);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // The processor result is valid on the cycle the counter reads 1.
        if (wait_q == WAIT_W'(1)) begin
          out_pixel_d = result_pixel;
          wait_d      = '0;
          state_d     = S_OUTPUT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = S_DONE;
          end else begin
            k_d      = '0;
            cell_a_d = '0;
            cell_b_d = '0;
            state_d  = S_GATHER;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cell_a    = cell_a_q;
  assign cell_b    = cell_b_q;
  assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_cell_sequencer.sv
// Randomised self-checking bench for cell_sequencer; the bench acts as pixel
// source, a cycle-stamped cell processor and the output consumer.
module tb_cell_sequencer;
  localparam int PIXEL_W      = 24;
  localparam int CELL_PIXELS  = 9;
  localparam int PROC_LATENCY = 4;
  localparam int CNT_W        = 16;
  localparam int CELL_W       = PIXEL_W * CELL_PIXELS;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CNT_W-1:0]    num_cells;
  logic                pix_valid;
  logic                pix_ready;
  logic [31:0]         pix_a;
  logic [31:0]         pix_b;
  logic [CELL_W-1:0]   cell_a;
  logic [CELL_W-1:0]   cell_b;
  logic                cell_issue;
  logic [PIXEL_W-1:0]  result_pixel;
  logic                out_valid;
  logic                out_ready;
  logic [PIXEL_W-1:0]  out_pixel;
  logic                busy;
  logic                done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cell_sequencer #(
    .PIXEL_W(PIXEL_W), .CELL_PIXELS(CELL_PIXELS),
    .PROC_LATENCY(PROC_LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_cells(num_cells),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_a(pix_a), .pix_b(pix_b),
    .cell_a(cell_a), .cell_b(cell_b), .cell_issue(cell_issue),
    .result_pixel(result_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Processor stand-in: a different result every cycle, so the captured value
  // identifies exactly which cycle was sampled.
  function automatic logic [PIXEL_W-1:0] res_fn(input int c);
    logic [31:0] t;
    t = c * 32'h9E3779B1;
    return t[PIXEL_W-1:0] ^ 24'h5A5A5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    result_pixel = res_fn(cyc);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; num_cells = '0; pix_valid = 1'b0;
    pix_a = '0; pix_b = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One pass: pat 0 random pixels, 1 counting pattern, 2 upper-byte garbage.
  // gap_mode 0 continuous, 1 valid 1,0,0 repeating, 2 random valid.
  task automatic run_pass(input int num, input int pat, input int gap_mode,
                          input int stall_cell, input int stall_len,
                          input int abort_cell, input bit hold_start);
    logic [CELL_W-1:0]  ea, eb;
    logic [31:0]        pa, pb;
    logic [PIXEL_W-1:0] ep;
    int beats, last, guard, gap_i;
    last = 0;
    start = 1'b1;
    num_cells = CNT_W'(num);
    step();
    start = hold_start;
    num_cells = CNT_W'($urandom);
    for (int c = 0; c < num; c++) begin
      ea = '0; eb = '0; beats = 0; guard = 0; gap_i = 0;
      checks++;
      if ({cell_a, cell_b} !== '0) begin
        errors++;
        $display("FAIL gather_clear cell %0d: got a=%h b=%h expected 0", c, cell_a, cell_b);
      end
      while (beats < CELL_PIXELS) begin
        if (guard++ > 200) begin
          errors++;
          $display("FAIL gather_timeout cell %0d: got %0d beats expected %0d", c, beats, CELL_PIXELS);
          return;
        end
        checks++;
        if ({pix_ready, cell_issue, out_valid, done, busy} !== 5'b10001) begin
          errors++;
          $display("FAIL gather_flags cell %0d: got %b expected 10001", c,
                   {pix_ready, cell_issue, out_valid, done, busy});
        end
        if (gap_mode == 0)      pix_valid = 1'b1;
        else if (gap_mode == 1) pix_valid = ((gap_i % 3) == 0);
        else                    pix_valid = 1'($urandom_range(0, 1));
        gap_i++;
        if (pat == 1) begin
          pa = 32'(beats + 1);
          pb = 32'h100 + 32'(beats);
        end else if (pat == 2) begin
          pa = 32'hFF123456;
          pb = $urandom | 32'hFF000000;
        end else begin
          pa = $urandom;
          pb = $urandom;
        end
        pix_a = pa;
        pix_b = pb;
        if (pix_valid && pix_ready) begin
          ea[beats*PIXEL_W +: PIXEL_W] = pa[PIXEL_W-1:0];
          eb[beats*PIXEL_W +: PIXEL_W] = pb[PIXEL_W-1:0];
          beats++;
          last = cyc;
        end
        step();
      end
      pix_valid = 1'($urandom_range(0, 1));
      pix_a = $urandom;
      pix_b = $urandom;
      checks++;
      if ({cell_issue, pix_ready, cell_a, cell_b} !== {1'b1, 1'b0, ea, eb}) begin
        errors++;
        $display("FAIL issue cell %0d: got issue=%b rdy=%b a=%h b=%h expected issue=1 rdy=0 a=%h b=%h",
                 c, cell_issue, pix_ready, cell_a, cell_b, ea, eb);
      end
      step();
      guard = 0;
      while (out_valid !== 1'b1) begin
        checks++;
        if ({cell_issue, pix_ready, done, busy, cell_a, cell_b} !== {4'b0001, ea, eb}) begin
          errors++;
          $display("FAIL wait_hold cell %0d: got flags=%b a=%h expected flags=0001 a=%h",
                   c, {cell_issue, pix_ready, done, busy}, cell_a, ea);
        end
        if (abort_cell == c && guard == 1) begin
          rst = 1'b0;
          step();
          checks++;
          if ({pix_ready, cell_issue, out_valid, done, busy, out_pixel, cell_a, cell_b} !== '0) begin
            errors++;
            $display("FAIL reset_abort: got flags=%b out=%h a=%h expected all 0",
                     {pix_ready, cell_issue, out_valid, done, busy}, out_pixel, cell_a);
          end
          rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
          step();
          checks++;
          if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_done: got done,busy=%b expected 00", {done, busy});
          end
          return;
        end
        if (guard++ > PROC_LATENCY + 10) begin
          errors++;
          $display("FAIL wait_timeout cell %0d: got out_valid=%b expected 1", c, out_valid);
          return;
        end
        step();
      end
      checks++;
      if (cyc !== last + 2 + PROC_LATENCY) begin
        errors++;
        $display("FAIL latency cell %0d: got %0d cycles expected %0d", c, cyc - last, 2 + PROC_LATENCY);
      end
      ep = res_fn(last + 1 + PROC_LATENCY);
      checks++;
      if (out_pixel !== ep) begin
        errors++;
        $display("FAIL out_pixel cell %0d: got %h expected %h", c, out_pixel, ep);
      end
      if (c == stall_cell) begin
        for (int s = 0; s < stall_len; s++) begin
          out_ready = 1'b0;
          pix_valid = 1'b1;
          step();
          checks++;
          if ({out_valid, pix_ready, done, out_pixel} !== {3'b100, ep}) begin
            errors++;
            $display("FAIL stall_hold cell %0d: got v=%b rdy=%b done=%b pix=%h expected 1,0,0,%h",
                     c, out_valid, pix_ready, done, out_pixel, ep);
          end
        end
      end
      out_ready = 1'b1;
      pix_valid = 1'b0;
      step();
      out_ready = 1'($urandom_range(0, 1));
      if (c == num - 1) begin
        start = 1'b0;
        checks++;
        if ({done, busy, out_valid, pix_ready} !== 4'b1100) begin
          errors++;
          $display("FAIL done_pulse: got done,busy,v,rdy=%b expected 1100",
                   {done, busy, out_valid, pix_ready});
        end
      end
    end
    step();
    checks++;
    if ({done, busy, pix_ready, cell_issue, out_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL idle_after: got done,busy,rdy,issue,v=%b expected 00000",
               {done, busy, pix_ready, cell_issue, out_valid});
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pix_ready, cell_issue, out_valid, done, busy, out_pixel, cell_a, cell_b} !== '0) begin
      errors++;
      $display("FAIL reset_state: got flags=%b out=%h expected all 0",
               {pix_ready, cell_issue, out_valid, done, busy}, out_pixel);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_pass(1, 1, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_mask();
    do_reset();
    run_pass(2, 2, 0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_stall();
    do_reset();
    run_pass(3, 0, 0, 1, 5, -1, 1'b0);
  endtask

  task automatic test_gaps();
    do_reset();
    run_pass(2, 0, 1, -1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_midop();
    do_reset();
    run_pass(4, 0, 0, -1, 0, 1, 1'b0);
    run_pass(4, 0, 2, 2, 3, -1, 1'b0);
  endtask

  task automatic test_zero_and_start();
    do_reset();
    start = 1'b1;
    num_cells = '0;
    step();
    start = 1'b0;
    checks++;
    if ({done, busy, pix_ready, cell_issue} !== 4'b1100) begin
      errors++;
      $display("FAIL zero_done: got done,busy,rdy,issue=%b expected 1100",
               {done, busy, pix_ready, cell_issue});
    end
    step();
    checks++;
    if ({done, busy, pix_ready, cell_issue} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_idle: got done,busy,rdy,issue=%b expected 0000",
               {done, busy, pix_ready, cell_issue});
    end
    run_pass(2, 0, 0, -1, 0, -1, 1'b1);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_pass(int'($urandom_range(1, 4)), 0, 2, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 6)), -1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    result_pixel = res_fn(0);
    test_reset();
    test_basic();
    test_mask();
    test_stall();
    test_gaps();
    test_reset_midop();
    test_zero_and_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
